// File: rtl/ctemp_pkg.sv
// ctemp_pkg: shared constants and helpers for the
// colour-temperature gain pipeline.
package ctemp_pkg;

  localparam int DEF_CH       = 3;
  localparam int DEF_DW       = 16;
  localparam int DEF_GW       = 8;
  localparam int DEF_GF       = 6;
  localparam int DEF_SATCNT_W = 24;
  localparam int PIPE_DEPTH   = 3;

  function automatic int unity_gain(input int gf);
    return 1 << gf;
  endfunction

  function automatic int lane_lsb(input int c, input int w);
    return c * w;
  endfunction

endpackage

// File: rtl/ctemp_gain_pipe_if.sv
// ctemp_gain_pipe_if: valid/ready pixel stream with
// start-of-frame marker.
interface ctemp_gain_pipe_if #(
  parameter int CH = 3,
  parameter int DW = 16
);

  logic              valid;
  logic              ready;
  logic              sof;
  logic [CH*DW-1:0]  data;

  modport master (
    output valid,
    output sof,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  sof,
    input  data,
    output ready
  );

endinterface

// File: rtl/ctemp_gain_lane.sv
// ctemp_gain_lane: one channel's multiply (S2) and round/saturate (S3).
// CTEMP_ROUND_EN selects round-half-up instead of truncation.
module ctemp_gain_lane
  import ctemp_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int GW = DEF_GW,
  parameter int GF = DEF_GF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] din,
  input  logic [GW-1:0] gain,
  input  logic          bypass,
  output logic [DW-1:0] dout,
  output logic          sat
);

  localparam int PW = DW + GW;
  localparam int RW = PW + 1 - GF;

  logic [PW-1:0] p_q;
  logic [DW-1:0] din_q;
  logic          byp_q;
  logic [RW-1:0] r;
  logic          ovf;
  logic [DW-1:0] dout_c;
  logic          sat_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q   <= '0;
      din_q <= '0;
      byp_q <= 1'b0;
    end else if (en) begin
      p_q   <= PW'(din) * PW'(gain);
      din_q <= din;
      byp_q <= bypass;
    end
  end

`ifdef CTEMP_ROUND_EN
  // one extra bit so the half-LSB carry cannot wrap
  logic [PW:0] ps;
  assign ps = {1'b0, p_q} + (PW+1)'(1 << (GF-1));
  assign r  = RW'(ps >> GF);
`else
  assign r  = RW'(p_q >> GF);
`endif

  assign ovf = |r[RW-1:DW];

  always_comb begin
    dout_c = r[DW-1:0];
    sat_c  = 1'b0;
    if (byp_q) begin
      dout_c = din_q;
    end else if (ovf) begin
      dout_c = '1;
      sat_c  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
      sat  <= 1'b0;
    end else if (en) begin
      dout <= dout_c;
      sat  <= sat_c;
    end
  end

endmodule

// File: rtl/ctemp_gain_pipe.sv
// ctemp_gain_pipe: 3-stage per-channel gain with frame-shadowed gains
// and saturation stats. CTEMP_ROUND_EN enables rounding in the lanes.
module ctemp_gain_pipe
  import ctemp_pkg::*;
#(
  parameter int CH       = DEF_CH,
  parameter int DW       = DEF_DW,
  parameter int GW       = DEF_GW,
  parameter int GF       = DEF_GF,
  parameter int SATCNT_W = DEF_SATCNT_W
) (
  input  logic                clk,
  input  logic                rst,
  ctemp_gain_pipe_if.slave    s,
  ctemp_gain_pipe_if.master   m,
  input  logic [CH*GW-1:0]    cfg_gain,
  input  logic                cfg_bypass,
  output logic [SATCNT_W-1:0] sat_count
);

  localparam logic [GW-1:0] UNITY = GW'(unity_gain(GF));

  logic                en;
  logic                acc;
  logic                sof_acc;
  logic                hs;
  logic [CH*GW-1:0]    gain_act;
  logic                byp_act;
  logic [CH*GW-1:0]    gain1;
  logic                byp1;
  logic [CH*DW-1:0]    din1;
  logic                v1, v2, v3;
  logic                sof1, sof2, sof3;
  logic [CH*DW-1:0]    dout_all;
  logic [CH-1:0]       lane_sat;
  logic                beat_sat;
  logic [SATCNT_W-1:0] run;

  assign en      = !v3 || m.ready;
  assign s.ready = en;
  assign acc     = s.valid && en;
  assign sof_acc = acc && s.sof;
  assign hs      = v3 && m.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      gain_act <= {CH{UNITY}};
      byp_act  <= 1'b0;
    end else if (sof_acc) begin
      gain_act <= cfg_gain;
      byp_act  <= cfg_bypass;
    end
  end

  // the SOF beat itself uses the freshly loaded gains
  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      sof1  <= 1'b0;
      din1  <= '0;
      gain1 <= {CH{UNITY}};
      byp1  <= 1'b0;
    end else if (en) begin
      v1    <= s.valid;
      sof1  <= s.valid && s.sof;
      din1  <= s.data;
      gain1 <= sof_acc ? cfg_gain : gain_act;
      byp1  <= sof_acc ? cfg_bypass : byp_act;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2   <= 1'b0;
      v3   <= 1'b0;
      sof2 <= 1'b0;
      sof3 <= 1'b0;
    end else if (en) begin
      v2   <= v1;
      v3   <= v2;
      sof2 <= sof1;
      sof3 <= sof2;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    ctemp_gain_lane #(
      .DW (DW),
      .GW (GW),
      .GF (GF)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .din    (din1[lane_lsb(c, DW) +: DW]),
      .gain   (gain1[lane_lsb(c, GW) +: GW]),
      .bypass (byp1),
      .dout   (dout_all[lane_lsb(c, DW) +: DW]),
      .sat    (lane_sat[c])
    );
  end

  assign m.valid  = v3;
  assign m.sof    = sof3;
  assign m.data   = dout_all;
  assign beat_sat = |lane_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      run       <= '0;
      sat_count <= '0;
    end else if (hs) begin
      if (sof3) begin
        sat_count <= run;
        run       <= SATCNT_W'(beat_sat);
      end else if (beat_sat && run != '1) begin
        run <= run + SATCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ctemp_gain_pipe.sv
// tb_ctemp_gain_pipe: directed and random checks of the gain pipe
// against an arithmetic frame/gain model.
module tb_ctemp_gain_pipe;

  typedef struct {
    logic [47:0] data;
    bit          sof;
    bit          sat;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] cfg_gain;
  logic        cfg_bypass;
  logic [23:0] sat_count;

  ctemp_gain_pipe_if #(.CH(3), .DW(16)) s_if ();
  ctemp_gain_pipe_if #(.CH(3), .DW(16)) m_if ();

  ctemp_gain_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .s          (s_if),
    .m          (m_if),
    .cfg_gain   (cfg_gain),
    .cfg_bypass (cfg_bypass),
    .sat_count  (sat_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  beat_t       q[$];
  int          act_g[3] = '{64, 64, 64};
  bit          act_b    = 1'b0;
  longint      run      = 0;
  logic [23:0] exp_sat  = '0;
  bit          last_acc = 1'b0;
  bit          hold_pend = 1'b0;
  logic [47:0] hold_data;
  logic        hold_sof;

  function automatic beat_t model(input logic [47:0] d, input bit sof);
    beat_t b;
    b.sof  = sof;
    b.sat  = 1'b0;
    b.data = '0;
    for (int c = 0; c < 3; c++) begin
      longint x;
      longint r;
      x = longint'(d[c*16 +: 16]);
      if (act_b) begin
        r = x;
      end else begin
        r = x * act_g[c];
`ifdef CTEMP_ROUND_EN
        r = r + 32;
`endif
        r = r / 64;
        if (r > 65535) begin
          r = 65535;
          b.sat = 1'b1;
        end
      end
      b.data[c*16 +: 16] = 16'(r);
    end
    return b;
  endfunction

  // one clock: sample at negedge, update model, return 1 after posedge
  task automatic cycle();
    beat_t e;
    @(negedge clk);
    n_checks++;
    if (sat_count !== exp_sat) begin
      n_fail++;
      $display("FAIL sat_count got=%0d exp=%0d", sat_count, exp_sat);
    end
    if (hold_pend) begin
      n_checks++;
      if (m_if.data !== hold_data || m_if.sof !== hold_sof) begin
        n_fail++;
        $display("FAIL stall_hold got=%h exp=%h", m_if.data, hold_data);
      end
    end
    hold_pend = m_if.valid && !m_if.ready && !rst;
    hold_data = m_if.data;
    hold_sof  = m_if.sof;
    last_acc  = 1'b0;
    if (rst) begin
      q.delete();
      run     = 0;
      exp_sat = '0;
      act_g   = '{64, 64, 64};
      act_b   = 1'b0;
    end else begin
      if (s_if.valid && s_if.ready) begin
        last_acc = 1'b1;
        if (s_if.sof) begin
          for (int c = 0; c < 3; c++) act_g[c] = int'(cfg_gain[c*8 +: 8]);
          act_b = cfg_bypass;
        end
        q.push_back(model(s_if.data, s_if.sof));
      end
      if (m_if.valid && m_if.ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_beat got=%h exp=none", m_if.data);
        end else begin
          e = q.pop_front();
          if (m_if.data !== e.data || m_if.sof !== e.sof) begin
            n_fail++;
            $display("FAIL beat got=%h/%b exp=%h/%b",
                     m_if.data, m_if.sof, e.data, e.sof);
          end
          if (e.sof) begin
            exp_sat = 24'(run);
            run     = e.sat ? 1 : 0;
          end else if (e.sat && run < 64'd16777215) begin
            run++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [47:0] d, input bit sof);
    int n = 0;
    s_if.valid = 1'b1;
    s_if.sof   = sof;
    s_if.data  = d;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 50);
    if (!last_acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout got=stalled exp=accept");
    end
    s_if.valid = 1'b0;
    s_if.sof   = 1'b0;
  endtask

  task automatic wait_out(output logic [47:0] d);
    int n = 0;
    while (!m_if.valid && n < 20) begin
      cycle();
      n++;
    end
    if (!m_if.valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL out_timeout got=no_valid exp=valid");
    end
    d = m_if.data;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    s_if.valid = 1'b0;
    s_if.sof   = 1'b0;
    s_if.data  = '0;
    m_if.ready = 1'b1;
    cfg_gain   = {3{8'd64}};
    cfg_bypass = 1'b0;
    @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;
    n_checks++;
    if (m_if.valid !== 1'b0 || m_if.sof !== 1'b0 ||
        m_if.data !== 48'd0 || sat_count !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_state got=%b/%b/%h/%0d exp=0/0/0/0",
               m_if.valid, m_if.sof, m_if.data, sat_count);
    end
    n_checks++;
    if (s_if.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got=%b exp=1", s_if.ready);
    end
  endtask

  task automatic test_gain();
    cfg_gain = {3{8'd96}};
    send({3{16'd1000}}, 1'b1);
    n_checks++;
    if (m_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_1 got=%b exp=0", m_if.valid);
    end
    cycle();
    n_checks++;
    if (m_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_2 got=%b exp=0", m_if.valid);
    end
    cycle();
    n_checks++;
    if (m_if.valid !== 1'b1 || m_if.data !== {3{16'd1500}}) begin
      n_fail++;
      $display("FAIL gain_1p5 got=%b/%h exp=1/%h",
               m_if.valid, m_if.data, {3{16'd1500}});
    end
    cycle();
    n_checks++;
    if (sat_count !== 24'd0) begin
      n_fail++;
      $display("FAIL gain_satcnt got=%0d exp=0", sat_count);
    end
  endtask

  task automatic test_saturation();
    logic [47:0] d;
    cfg_gain = {3{8'd128}};
    send({3{16'hF000}}, 1'b1);
    wait_out(d);
    n_checks++;
    if (d !== {3{16'hFFFF}}) begin
      n_fail++;
      $display("FAIL sat_value got=%h exp=%h", d, {3{16'hFFFF}});
    end
    cycle();
    send({3{16'd10}}, 1'b1);
    wait_out(d);
    n_checks++;
    if (d !== {3{16'd20}}) begin
      n_fail++;
      $display("FAIL gain_2x got=%h exp=%h", d, {3{16'd20}});
    end
    cycle();
    n_checks++;
    if (sat_count !== 24'd1) begin
      n_fail++;
      $display("FAIL sat_publish got=%0d exp=1", sat_count);
    end
  endtask

  task automatic test_round();
    logic [47:0] d;
    logic [47:0] e;
`ifdef CTEMP_ROUND_EN
    e = {3{16'd2}};
`else
    e = {3{16'd1}};
`endif
    cfg_gain = {3{8'd33}};
    send({3{16'd3}}, 1'b1);
    wait_out(d);
    n_checks++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL round got=%h exp=%h", d, e);
    end
    cycle();
  endtask

  task automatic test_midframe();
    logic [47:0] d;
    logic [47:0] x1;
    logic [47:0] x2;
    x1 = {3{16'd500}};
    x2 = {3{16'd1000}};
    cfg_gain = {3{8'd64}};
    send(x1, 1'b1);
    wait_out(d);
    cycle();
    cfg_gain = {3{8'd128}};
    send(x1, 1'b0);
    wait_out(d);
    n_checks++;
    if (d !== x1) begin
      n_fail++;
      $display("FAIL midframe_hold got=%h exp=%h", d, x1);
    end
    cycle();
    send(x1, 1'b1);
    wait_out(d);
    n_checks++;
    if (d !== x2) begin
      n_fail++;
      $display("FAIL sof_reload got=%h exp=%h", d, x2);
    end
    cycle();
    send(x1, 1'b0);
    wait_out(d);
    n_checks++;
    if (d !== x2) begin
      n_fail++;
      $display("FAIL after_sof got=%h exp=%h", d, x2);
    end
    cycle();
  endtask

  task automatic test_bypass();
    logic [47:0] d;
    cfg_gain   = {3{8'd255}};
    cfg_bypass = 1'b1;
    send({3{16'hF000}}, 1'b1);
    cfg_bypass = 1'b0;
    wait_out(d);
    n_checks++;
    if (d !== {3{16'hF000}}) begin
      n_fail++;
      $display("FAIL bypass got=%h exp=%h", d, {3{16'hF000}});
    end
    cycle();
  endtask

  task automatic test_stall();
    int n = 0;
    cfg_gain   = {8'd70, 8'd64, 8'd90};
    m_if.ready = 1'b0;
    send(48'h0001_0002_0003, 1'b1);
    send(48'h0100_0200_0300, 1'b0);
    send(48'h1000_2000_3000, 1'b0);
    s_if.valid = 1'b1;
    s_if.data  = 48'h4444_5555_6666;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (s_if.ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_ready got=%b exp=0", s_if.ready);
      end
      cycle();
    end
    m_if.ready = 1'b1;
    while (!last_acc && n < 10) begin
      cycle();
      n++;
    end
    s_if.valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      cycle();
      n++;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_drain got=%0d exp=0", q.size());
    end
  endtask

  task automatic test_random();
    int acc = 0;
    int n   = 0;
    s_if.valid = 1'b0;
    while (acc < 100 && n < 5000) begin
      if (!s_if.valid || last_acc) begin
        s_if.valid = ($urandom_range(0, 3) != 0);
        s_if.sof   = ($urandom_range(0, 15) == 0);
        s_if.data  = {16'($urandom), 16'($urandom), 16'($urandom)};
      end
      m_if.ready = ($urandom_range(0, 3) != 0);
      cfg_gain   = 24'($urandom);
      cfg_bypass = ($urandom_range(0, 7) == 0);
      cycle();
      if (last_acc) acc++;
      n++;
    end
    s_if.valid = 1'b0;
    s_if.sof   = 1'b0;
    m_if.ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      cycle();
      n++;
    end
    n_checks++;
    if (acc != 100 || q.size() != 0) begin
      n_fail++;
      $display("FAIL random_run got=%0d/%0d exp=100/0", acc, q.size());
    end
  endtask

  task automatic test_reset_flight();
    logic [47:0] d;
    cfg_gain   = {3{8'd128}};
    m_if.ready = 1'b1;
    send({3{16'hF000}}, 1'b1);
    send({3{16'd11}}, 1'b0);
    send({3{16'd12}}, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_checks++;
    if (m_if.valid !== 1'b0 || sat_count !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_flight got=%b/%0d exp=0/0",
               m_if.valid, sat_count);
    end
    send({3{16'd777}}, 1'b0);
    wait_out(d);
    n_checks++;
    if (d !== {3{16'd777}}) begin
      n_fail++;
      $display("FAIL post_reset_unity got=%h exp=%h", d, {3{16'd777}});
    end
    cycle();
  endtask

  initial begin
    test_reset();
    test_gain();
    test_saturation();
    test_round();
    test_midframe();
    test_bypass();
    test_stall();
    test_random();
    test_reset_flight();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
